// File: rtl/rdm_req_arbiter_pkg.sv
// rdm_arb_pkg: shared FSM encodings and source-ID width helper for the RDM request arbiter
package rdm_arb_pkg;
  localparam logic [0:0] REQ_IDLE = 1'b0;
  localparam logic [0:0] REQ_BUSY = 1'b1;
  localparam logic [0:0] RSP_HEAD = 1'b0;
  localparam logic [0:0] RSP_BODY = 1'b1;
  function automatic int idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rdm_req_arbiter_rr_pick.sv
// rdm_rr_pick: combinational round-robin picker, priority starts just after last_grant
module rdm_rr_pick #(
  parameter int NR_SRC = 2,
  parameter int IDW    = 1
) (
  input  logic [NR_SRC-1:0] eligible,
  input  logic [IDW-1:0]    last_grant,
  output logic              found,
  output logic [IDW-1:0]    idx
);
  logic [IDW-1:0] j;
  // walk from lowest to highest priority so the last hit is the winner
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = NR_SRC; k >= 1; k--) begin
      j = IDW'((int'(last_grant) + k) % NR_SRC);
      if (eligible[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end
endmodule

// File: rtl/rdm_req_arbiter.sv
// rdm_req_arbiter: packet round-robin request mux, response demux by tuser ID, per-source credits
module rdm_req_arbiter
  import rdm_arb_pkg::*;
#(
  parameter int NR_SRC          = 2,
  parameter int DATA_W          = 256,
  parameter int KEEP_W          = 32,
  parameter int USER_W          = 64,
  parameter int SRC_ID_LSB      = 56,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NR_SRC-1:0][DATA_W-1:0]  s_req_tdata,
  input  logic [NR_SRC-1:0][KEEP_W-1:0]  s_req_tkeep,
  input  logic [NR_SRC-1:0][USER_W-1:0]  s_req_tuser,
  input  logic [NR_SRC-1:0]              s_req_tlast,
  input  logic [NR_SRC-1:0]              s_req_tvalid,
  output logic [NR_SRC-1:0]              s_req_tready,
  output logic [DATA_W-1:0]              m_req_tdata,
  output logic [KEEP_W-1:0]              m_req_tkeep,
  output logic [USER_W-1:0]              m_req_tuser,
  output logic                           m_req_tlast,
  output logic                           m_req_tvalid,
  input  logic                           m_req_tready,
  input  logic [DATA_W-1:0]              s_rsp_tdata,
  input  logic [KEEP_W-1:0]              s_rsp_tkeep,
  input  logic [USER_W-1:0]              s_rsp_tuser,
  input  logic                           s_rsp_tlast,
  input  logic                           s_rsp_tvalid,
  output logic                           s_rsp_tready,
  output logic [NR_SRC-1:0][DATA_W-1:0]  m_rsp_tdata,
  output logic [NR_SRC-1:0][KEEP_W-1:0]  m_rsp_tkeep,
  output logic [NR_SRC-1:0][USER_W-1:0]  m_rsp_tuser,
  output logic [NR_SRC-1:0]              m_rsp_tlast,
  output logic [NR_SRC-1:0]              m_rsp_tvalid,
  input  logic [NR_SRC-1:0]              m_rsp_tready,
  output logic [NR_SRC*8-1:0]            outstanding,
  output logic                           err_bad_id
);
  localparam int IDW  = idw(NR_SRC);
  // the ID check looks at up to a byte of tuser so IDs beyond the routed width are still caught
  localparam int CHKW = (USER_W - SRC_ID_LSB) < 8 ? (USER_W - SRC_ID_LSB) : 8;
  logic [0:0]                 req_st_q, req_st_d, rsp_st_q, rsp_st_d;
  logic [IDW-1:0]             sel_q, sel_d, last_q, last_d, dst_q, dst_d, pick_idx, cur_dst;
  logic                       pick_found, req_done, rsp_hs, head_bad, cur_drop, drop_q, drop_d;
  logic                       err_q, err_d;
  logic [NR_SRC-1:0]          eligible, inc, dec, uf;
  logic [NR_SRC-1:0][7:0]     cnt_q, cnt_d;
  logic [CHKW-1:0]            rsp_id;
  rdm_rr_pick #(.NR_SRC(NR_SRC), .IDW(IDW)) u_pick (
    .eligible   (eligible),
    .last_grant (last_q),
    .found      (pick_found),
    .idx        (pick_idx)
  );
  // request side: grant FSM and stream mux with the source ID stamped into tuser
  always_comb begin
    for (int i = 0; i < NR_SRC; i++) eligible[i] = s_req_tvalid[i] && cnt_q[i] != 8'(MAX_OUTSTANDING);
    m_req_tdata  = s_req_tdata[sel_q];
    m_req_tkeep  = s_req_tkeep[sel_q];
    m_req_tlast  = s_req_tlast[sel_q];
    m_req_tuser  = s_req_tuser[sel_q];
    m_req_tuser[SRC_ID_LSB+:IDW] = sel_q;
    m_req_tvalid = req_st_q == REQ_BUSY && s_req_tvalid[sel_q];
    s_req_tready = '0;
    s_req_tready[sel_q] = req_st_q == REQ_BUSY && m_req_tready;
    req_done = m_req_tvalid && m_req_tready && m_req_tlast;
    req_st_d = req_st_q == REQ_BUSY ? (req_done ? REQ_IDLE : REQ_BUSY) : (pick_found ? REQ_BUSY : REQ_IDLE);
    sel_d    = req_st_q == REQ_IDLE && pick_found ? pick_idx : sel_q;
    last_d   = req_done ? sel_q : last_q;
  end
  // response side: route by head-beat ID, hold the route for the body, drop bad IDs
  always_comb begin
    rsp_id   = s_rsp_tuser[SRC_ID_LSB+:CHKW];
    head_bad = int'(rsp_id) >= NR_SRC;
    cur_drop = rsp_st_q == RSP_BODY ? drop_q : head_bad;
    cur_dst  = rsp_st_q == RSP_BODY ? dst_q : rsp_id[IDW-1:0];
    s_rsp_tready = rst_n && (cur_drop || m_rsp_tready[cur_dst]);
    m_rsp_tvalid = '0;
    m_rsp_tvalid[cur_dst] = rst_n && s_rsp_tvalid && !cur_drop;
    for (int i = 0; i < NR_SRC; i++) begin
      m_rsp_tdata[i] = s_rsp_tdata;
      m_rsp_tkeep[i] = s_rsp_tkeep;
      m_rsp_tuser[i] = s_rsp_tuser;
      m_rsp_tlast[i] = s_rsp_tlast;
    end
    rsp_hs   = s_rsp_tvalid && s_rsp_tready;
    rsp_st_d = rsp_hs ? (s_rsp_tlast ? RSP_HEAD : RSP_BODY) : rsp_st_q;
    dst_d    = rsp_hs && rsp_st_q == RSP_HEAD ? cur_dst : dst_q;
    drop_d   = rsp_hs && rsp_st_q == RSP_HEAD ? cur_drop : drop_q;
  end
  // credit counters: grant-complete adds, response-complete subtracts, underflow flags an error
  always_comb begin
    for (int i = 0; i < NR_SRC; i++) begin
      inc[i]   = req_done && sel_q == IDW'(i);
      dec[i]   = rsp_hs && s_rsp_tlast && !cur_drop && cur_dst == IDW'(i);
      uf[i]    = dec[i] && !inc[i] && cnt_q[i] == 8'd0;
      cnt_d[i] = inc[i] && !dec[i] ? cnt_q[i] + 8'd1 :
                 dec[i] && !inc[i] && !uf[i] ? cnt_q[i] - 8'd1 : cnt_q[i];
    end
    err_d = err_q || (rsp_hs && rsp_st_q == RSP_HEAD && head_bad) || |uf;
  end
  assign outstanding = cnt_q;
  assign err_bad_id  = err_q;
  // state registers, async active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_st_q <= REQ_IDLE;
      rsp_st_q <= RSP_HEAD;
      sel_q    <= '0;
      last_q   <= IDW'(NR_SRC - 1);
      dst_q    <= '0;
      drop_q   <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      req_st_q <= req_st_d;
      rsp_st_q <= rsp_st_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      dst_q    <= dst_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_rdm_req_arbiter.sv
// tb_rdm_req_arbiter: directed vector table plus hand sequences for the request arbiter
module tb_rdm_req_arbiter;
  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [1:0][255:0]    s_req_tdata = '0;
  logic [1:0][31:0]     s_req_tkeep = '1;
  logic [1:0][63:0]     s_req_tuser = '0;
  logic [1:0]           s_req_tlast = '0, s_req_tvalid = '0, s_req_tready;
  logic [255:0]         m_req_tdata;
  logic [31:0]          m_req_tkeep;
  logic [63:0]          m_req_tuser;
  logic                 m_req_tlast, m_req_tvalid, m_req_tready = 1'b0;
  logic [255:0]         s_rsp_tdata = '0;
  logic [31:0]          s_rsp_tkeep = '1;
  logic [63:0]          s_rsp_tuser = '0;
  logic                 s_rsp_tlast = 1'b0, s_rsp_tvalid = 1'b0, s_rsp_tready;
  logic [1:0][255:0]    m_rsp_tdata;
  logic [1:0][31:0]     m_rsp_tkeep;
  logic [1:0][63:0]     m_rsp_tuser;
  logic [1:0]           m_rsp_tlast, m_rsp_tvalid, m_rsp_tready = '0;
  logic [15:0]          outstanding;
  logic                 err_bad_id;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  rdm_req_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .s_req_tdata(s_req_tdata), .s_req_tkeep(s_req_tkeep), .s_req_tuser(s_req_tuser),
    .s_req_tlast(s_req_tlast), .s_req_tvalid(s_req_tvalid), .s_req_tready(s_req_tready),
    .m_req_tdata(m_req_tdata), .m_req_tkeep(m_req_tkeep), .m_req_tuser(m_req_tuser),
    .m_req_tlast(m_req_tlast), .m_req_tvalid(m_req_tvalid), .m_req_tready(m_req_tready),
    .s_rsp_tdata(s_rsp_tdata), .s_rsp_tkeep(s_rsp_tkeep), .s_rsp_tuser(s_rsp_tuser),
    .s_rsp_tlast(s_rsp_tlast), .s_rsp_tvalid(s_rsp_tvalid), .s_rsp_tready(s_rsp_tready),
    .m_rsp_tdata(m_rsp_tdata), .m_rsp_tkeep(m_rsp_tkeep), .m_rsp_tuser(m_rsp_tuser),
    .m_rsp_tlast(m_rsp_tlast), .m_rsp_tvalid(m_rsp_tvalid), .m_rsp_tready(m_rsp_tready),
    .outstanding(outstanding), .err_bad_id(err_bad_id)
  );
  typedef struct packed {
    logic [1:0] v, l;
    logic       r, ev, eid;
    logic [1:0] er;
    logic [7:0] o0, o1;
  } vec_t;
  vec_t tbl [14];
  int   got [$];
  int   exp_g [13] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0};
  localparam logic [255:0] D0 = 256'hd0d0, D1 = 256'hd1d1;
  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = '{2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 8'd1, 8'd0};
    tbl[1]  = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 2'b10, 8'd1, 8'd0};
    tbl[2]  = '{2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 8'd1, 8'd1};
    tbl[3]  = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 2'b01, 8'd1, 8'd1};
    tbl[4]  = '{2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 8'd2, 8'd1};
    tbl[5]  = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 2'b10, 8'd2, 8'd1};
    tbl[6]  = '{2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 8'd2, 8'd2};
    tbl[7]  = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 2'b01, 8'd2, 8'd2};
    tbl[8]  = '{2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 8'd3, 8'd2};
    tbl[9]  = '{2'b11, 2'b01, 1'b1, 1'b1, 1'b1, 2'b10, 8'd3, 8'd2};
    tbl[10] = '{2'b11, 2'b11, 1'b0, 1'b1, 1'b1, 2'b00, 8'd3, 8'd2};
    tbl[11] = '{2'b11, 2'b11, 1'b0, 1'b1, 1'b1, 2'b00, 8'd3, 8'd2};
    tbl[12] = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 2'b10, 8'd3, 8'd2};
    tbl[13] = '{2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 8'd3, 8'd3};
    m_rsp_tready = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mvalid", m_req_tvalid, 0);
    chk("rst_sready", s_req_tready, 0);
    chk("rst_rspready", s_rsp_tready, 0);
    chk("rst_out", outstanding, 0);
    chk("rst_err", err_bad_id, 0);
    next();
    rst_n = 1'b1;
    m_rsp_tready = 2'b00;
    s_req_tvalid = 2'b01;
    s_req_tuser[0] = 64'h0123_4567_89ab_cdef;
    s_req_tdata[0] = 256'hb0;
    m_req_tready = 1'b1;
    @(negedge clk);
    chk("t1_bubble", m_req_tvalid, 0);
    next();
    for (int b = 0; b < 3; b++) begin
      s_req_tdata[0] = 256'hb0 + 256'(b);
      s_req_tlast[0] = (b == 2);
      @(negedge clk);
      chk("t1_valid", m_req_tvalid, 1);
      chk("t1_data", m_req_tdata, 256'hb0 + 256'(b));
      chk("t1_user", m_req_tuser, 64'h0023_4567_89ab_cdef);
      chk("t1_sready", s_req_tready, 2'b01);
      next();
    end
    s_req_tvalid = '0;
    s_req_tlast  = '0;
    @(negedge clk);
    chk("t1_idle", m_req_tvalid, 0);
    chk("t1_out0", outstanding[7:0], 1);
    next();
    s_req_tuser = '0;
    s_req_tdata[0] = D0;
    s_req_tdata[1] = D1;
    for (int r = 0; r < 14; r++) begin
      s_req_tvalid = tbl[r].v;
      s_req_tlast  = tbl[r].l;
      m_req_tready = tbl[r].r;
      @(negedge clk);
      chk($sformatf("tbl%0d_mvalid", r), m_req_tvalid, tbl[r].ev);
      chk($sformatf("tbl%0d_sready", r), s_req_tready, tbl[r].er);
      chk($sformatf("tbl%0d_out0", r), outstanding[7:0], tbl[r].o0);
      chk($sformatf("tbl%0d_out1", r), outstanding[15:8], tbl[r].o1);
      if (tbl[r].ev) begin
        chk($sformatf("tbl%0d_id", r), m_req_tuser[56], tbl[r].eid);
        chk($sformatf("tbl%0d_data", r), m_req_tdata, tbl[r].eid ? D1 : D0);
      end
      next();
    end
    s_req_tvalid = '0;
    m_rsp_tready = 2'b11;
    for (int k = 0; k < 3; k++) begin
      s_rsp_tvalid = 1'b1;
      s_rsp_tlast  = 1'b1;
      s_rsp_tuser  = 64'h0;
      s_rsp_tdata  = 256'hc0 + 256'(k);
      @(negedge clk);
      chk("drain_mvalid", m_rsp_tvalid, 2'b01);
      chk("drain_sready", s_rsp_tready, 1);
      chk("drain_data", m_rsp_tdata[0], 256'hc0 + 256'(k));
      next();
    end
    s_rsp_tvalid = 1'b0;
    @(negedge clk);
    chk("drain_out0", outstanding[7:0], 0);
    chk("drain_out1", outstanding[15:8], 3);
    next();
    s_req_tvalid = 2'b11;
    s_req_tlast  = 2'b11;
    m_req_tready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m_req_tvalid && m_req_tready) got.push_back(int'(m_req_tuser[56]));
      next();
    end
    chk("t3_ngrant", got.size(), 13);
    for (int i = 0; i < 13 && i < got.size(); i++) chk($sformatf("t3_grant%0d", i), got[i], exp_g[i]);
    chk("t3_out0", outstanding[7:0], 8);
    chk("t3_out1", outstanding[15:8], 8);
    s_rsp_tvalid = 1'b1;
    s_rsp_tuser  = 64'h0100_0000_0000_0000;
    @(negedge clk);
    chk("t3_rsp_ready", s_rsp_tready, 1);
    chk("t3_rsp_valid", m_rsp_tvalid, 2'b10);
    next();
    s_rsp_tvalid = 1'b0;
    got.delete();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m_req_tvalid && m_req_tready) got.push_back(int'(m_req_tuser[56]));
      next();
    end
    chk("t3_regrant_n", got.size(), 1);
    if (got.size() > 0) chk("t3_regrant_id", got[0], 1);
    s_req_tvalid = '0;
    s_rsp_tvalid = 1'b1;
    s_rsp_tlast  = 1'b0;
    s_rsp_tuser  = 64'h0100_0000_0000_00a5;
    m_rsp_tready = 2'b01;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t5_stall_ready", s_rsp_tready, 0);
      chk("t5_stall_valid", m_rsp_tvalid, 2'b10);
      next();
    end
    m_rsp_tready = 2'b11;
    @(negedge clk);
    chk("t5_b0_ready", s_rsp_tready, 1);
    chk("t5_b0_valid", m_rsp_tvalid, 2'b10);
    next();
    s_rsp_tlast = 1'b1;
    s_rsp_tuser = 64'h0000_0000_0000_005a;
    @(negedge clk);
    chk("t5_b1_valid", m_rsp_tvalid, 2'b10);
    chk("t5_b1_user", m_rsp_tuser[1], 64'h5a);
    chk("t5_b1_ready", s_rsp_tready, 1);
    next();
    s_rsp_tvalid = 1'b0;
    @(negedge clk);
    chk("t5_out1", outstanding[15:8], 7);
    chk("t5_err", err_bad_id, 0);
    next();
    s_rsp_tvalid = 1'b1;
    s_rsp_tlast  = 1'b0;
    s_rsp_tuser  = 64'h0300_0000_0000_0000;
    m_rsp_tready = 2'b00;
    @(negedge clk);
    chk("t6_b0_ready", s_rsp_tready, 1);
    chk("t6_b0_valid", m_rsp_tvalid, 0);
    chk("t6_b0_err", err_bad_id, 0);
    next();
    s_rsp_tlast = 1'b1;
    s_rsp_tuser = 64'h0;
    @(negedge clk);
    chk("t6_b1_ready", s_rsp_tready, 1);
    chk("t6_b1_valid", m_rsp_tvalid, 0);
    chk("t6_b1_err", err_bad_id, 1);
    next();
    s_rsp_tvalid = 1'b0;
    @(negedge clk);
    chk("t6_out0", outstanding[7:0], 8);
    chk("t6_out1", outstanding[15:8], 7);
    chk("t6_err_sticky", err_bad_id, 1);
    next();
    s_req_tvalid = 2'b10;
    s_req_tlast  = 2'b00;
    m_req_tready = 1'b1;
    @(negedge clk);
    chk("rr_bubble", m_req_tvalid, 0);
    next();
    @(negedge clk);
    chk("rr_busy", m_req_tvalid, 1);
    next();
    #1;
    rst_n = 1'b0;
    s_rsp_tvalid = 1'b1;
    m_rsp_tready = 2'b11;
    #1;
    chk("rr_mvalid", m_req_tvalid, 0);
    chk("rr_sready", s_req_tready, 0);
    chk("rr_rspready", s_rsp_tready, 0);
    chk("rr_rspvalid", m_rsp_tvalid, 0);
    chk("rr_out", outstanding, 0);
    chk("rr_err", err_bad_id, 0);
    next();
    rst_n = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
